// File: rtl/crc_stream_checker_pkg.sv
// crc_pkg: shared definitions for the streaming CRC checker.
//   - state_e       : frame FSM states (IDLE, ACC, RPT)
//   - *_DEF         : default CRC_W / POLY / INIT / DATA_W
//   - crc_w_ok()    : legal CRC width range check (4..32)
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no frame open
        ACC  = 2'd1,  // frame open, accumulating beats
        RPT  = 2'd2   // result held until taken
    } state_e;

    localparam int unsigned CRC_W_DEF  = 8;
    localparam logic [31:0] POLY_DEF   = 32'h0000_0007;
    localparam logic [31:0] INIT_DEF   = 32'h0000_0000;
    localparam int unsigned DATA_W_DEF = 8;

    localparam int unsigned CRC_W_MIN = 4;
    localparam int unsigned CRC_W_MAX = 32;

    function automatic bit crc_w_ok(input int unsigned w);
        return (w >= CRC_W_MIN) && (w <= CRC_W_MAX);
    endfunction

    localparam bit CRC_W_DEF_OK = crc_w_ok(CRC_W_DEF);

endpackage

// File: rtl/crc_stream_checker_if.sv
// crc_stream_checker_if: beat stream + result handshake bundle.
//   Beat side  : in_valid, in_ready, in_data[DATA_W], in_last, in_crc[CRC_W]
//   Result side: res_valid, res_ready, res_err, res_crc[CRC_W]
//   master : frame source / result consumer
//   slave  : the checker
interface crc_stream_checker_if
    import crc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CRC_W  = CRC_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [CRC_W-1:0]  in_crc;
    logic              res_valid;
    logic              res_ready;
    logic              res_err;
    logic [CRC_W-1:0]  res_crc;

    modport master (
        output in_valid, in_data, in_last, in_crc, res_ready,
        input  in_ready, res_valid, res_err, res_crc
    );

    modport slave (
        input  in_valid, in_data, in_last, in_crc, res_ready,
        output in_ready, res_valid, res_err, res_crc
    );
endinterface

// File: rtl/crc_stream_checker_step.sv
// crc_step: combinational fold of one DATA_W beat into a CRC_W register.
//   Serial MSB-first, no reflection, no final XOR.
//   crc_i  : current CRC register
//   data_i : beat, bit DATA_W-1 processed first
//   crc_o  : CRC after all DATA_W shifts
module crc_step #(
    parameter int unsigned      CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = 8'h07,
    parameter int unsigned      DATA_W = 8
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);
    logic fb;

    always_comb begin
        fb    = 1'b0;
        crc_o = crc_i;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb    = crc_o[CRC_W-1] ^ data_i[DATA_W-1-i];
            crc_o = {crc_o[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end
endmodule

// File: rtl/crc_stream_checker.sv
// crc_stream_checker: streaming frame CRC check with held pass/fail result.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   s       : crc_stream_checker_if.slave (beat stream in, result out)
//   err_cnt : saturating count of failed frames
// Optional feature macro: CRC_ERR_CNT_EN builds the failed-frame counter;
// without it err_cnt is tied to zero.
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W  = CRC_W_DEF,
    parameter logic [CRC_W-1:0] POLY   = POLY_DEF[CRC_W-1:0],
    parameter logic [CRC_W-1:0] INIT   = INIT_DEF[CRC_W-1:0],
    parameter int unsigned      DATA_W = DATA_W_DEF,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    crc_stream_checker_if.slave  s,
    output logic [CNT_W-1:0]     err_cnt
);
    if (!crc_w_ok(CRC_W)) begin : g_bad_crc_w
        $error("crc_stream_checker: CRC_W must be 4..32");
    end

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] res_crc_q, res_crc_d;
    logic             res_err_q, res_err_d;

    logic [CRC_W-1:0] step_crc;
    logic             accept;
    logic             frame_end;
    logic             mismatch;

    // One step unit serves both the running CRC and the final result: the
    // result of the last beat is exactly the accumulated value after it.
    crc_step #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_step (
        .crc_i  (crc_q),
        .data_i (s.in_data),
        .crc_o  (step_crc)
    );

    assign s.in_ready  = (state_q != RPT);
    assign s.res_valid = (state_q == RPT);
    assign s.res_err   = res_err_q;
    assign s.res_crc   = res_crc_q;

    assign accept    = s.in_valid & s.in_ready;
    assign frame_end = accept & s.in_last;
    assign mismatch  = (step_crc != s.in_crc);

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        res_crc_d = res_crc_q;
        res_err_d = res_err_q;
        unique case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    crc_d = step_crc;
                    if (s.in_last) begin
                        state_d   = RPT;
                        res_crc_d = step_crc;
                        res_err_d = mismatch;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            RPT: begin
                if (s.res_ready) begin
                    state_d = IDLE;
                    crc_d   = INIT;
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            res_crc_q <= '0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            res_crc_q <= res_crc_d;
            res_err_q <= res_err_d;
        end
    end

`ifdef CRC_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (frame_end && mismatch && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif
endmodule

// File: doc/crc_stream_checker.md
# crc_stream_checker

Parametrised, streaming successor to the combinational 8-bit CRC check. Accepts a frame as a sequence of DATA_W-bit beats on a valid/ready interface and folds one beat per cycle into a CRC_W-bit register. On the last beat it compares the final CRC against the received CRC and presents a held pass/fail result. Sits between the link receive path and frame consumers.

## Interface
- CRC_W, 8: CRC width in bits, 4..32
- POLY, 8'h07: generator polynomial, implicit x^CRC_W term omitted
- INIT, 0: CRC register value at frame start
- DATA_W, 8: beat width in bits, 1..64
- CNT_W, 16: error counter width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  DATA_W  payload beat, MSB processed first
- in_last  in  1  final beat of frame
- in_crc  in  CRC_W  received CRC, sampled only on the accepted last beat
- res_valid  out  1  result available, held until taken
- res_ready  in  1  consumer takes result
- res_err  out  1  1 = computed CRC differs from in_crc
- res_crc  out  CRC_W  computed CRC of the frame
- err_cnt  out  CNT_W  saturating count of failed frames

## Operation
- FSM states: IDLE (no frame open), ACC (frame open), RPT (result held).
- IDLE: accepted beat with in_last=0 -> ACC; with in_last=1 -> RPT (single-beat frame).
- ACC: accepted beat with in_last=0 stays in ACC; with in_last=1 -> RPT.
- RPT: res_valid=1; on res_ready -> IDLE, CRC register reloaded with INIT.
- in_ready = 1 in IDLE and ACC, 0 in RPT. No beat is ever accepted while a result is pending.
- Per accepted beat: crc <= step(crc, in_data). This applies DATA_W serial MSB-first shifts. Each shift computes fb = crc[CRC_W-1] ^ bit, then crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0). There is no reflection and no final XOR.
- On the accepted last beat: res_crc <= step(crc, in_data), and res_err <= (that value != in_crc). Both are held stable through RPT.
- in_valid without in_ready has no effect. in_data, in_last and in_crc are don't-care when not accepted.

## Timing
- Throughput: one beat per cycle in IDLE/ACC.
- Latency: last beat accepted at edge N gives res_valid=1 after edge N. The next frame can be accepted from the cycle after the res handshake edge, so there is a minimum one idle cycle between frames.
- Reset values: state IDLE, CRC register INIT, in_ready 1 after reset deasserts, res_valid 0, res_err 0, res_crc 0, err_cnt 0.
- Reset mid-frame or mid-RPT: the partial frame and any pending result are discarded without being counted, and the block returns to IDLE.
- res_ready while res_valid=0 is ignored.

## Configuration
- CRC_ERR_CNT_EN defined: err_cnt increments by 1 on the edge entering RPT with res_err=1. It saturates at all-ones and is cleared only by rst.
- Not defined: no counter logic is built, and err_cnt is tied to 0. The port list is unchanged.

## Structure
- Package crc_pkg holds:
  - the FSM state enum (IDLE, ACC, RPT);
  - the default CRC_W, POLY, INIT and DATA_W constants;
  - a localparam check that CRC_W is between 4 and 32.
- Sub-module crc_step is purely combinational and implements step(crc, data) for one DATA_W beat. Both the accumulate path and the result path use it.

## Test plan
All scenarios use defaults (CRC_W=8, POLY=8'h07, INIT=0, DATA_W=8) unless stated.
- Frame 0x31..0x39 ("123456789"), in_crc=0xF4, res_ready=1: res_valid one cycle after the last beat, res_crc=0xF4, res_err=0, err_cnt=0.
- Single beat 0x01 with in_last=1 and in_crc=0x00: direct IDLE->RPT, res_crc=0x07, res_err=1, err_cnt=1.
- Hold res_ready=0 for 5 cycles after a result: in_ready=0 and offered beats are not accepted, with res outputs stable. Releasing res_ready gives IDLE and in_ready=1 on the next cycle.
- Assert rst for 1 cycle mid-frame after 3 beats, then send a single beat 0x00 with in_crc=0x00: res_crc=0x00 and res_err=0, so the earlier partial frame has no effect.
- With CRC_ERR_CNT_EN and CNT_W=2, send 5 failing frames: err_cnt reads 1, 2, 3, 3, 3. Without the macro, err_cnt stays 0.
- With DATA_W=1, send "123456789" serially MSB-first with in_crc=0xF4: result is identical to the 8-bit run, with res_err=0.
